saturn_bus_ctrl: RTL

SATURN_BUS_CTRL -- requirements
Module: saturn_bus_ctrl

---
 rtl/saturn_bus_ctrl.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/saturn_bus_ctrl.sv
// Saturn-style nibble bus controller: turns core requests into CMD/ADDR/DATA
// bus cycles (4 clocks each) and mirrors the responder's PC and DP registers.
module saturn_bus_ctrl (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [1:0]  i_phase,
  input  logic        i_req,
  input  logic [2:0]  i_op,
  input  logic [19:0] i_addr,
  input  logic [3:0]  i_wdata,
  output logic        o_busy,
  output logic        o_done,
  output logic [3:0]  o_rdata,
  output logic [19:0] o_pc,
  output logic [19:0] o_dp,
  output logic        o_bus_strobe,
  output logic        o_bus_cmd_data,
  output logic [3:0]  o_bus_data_out,
  input  logic [3:0]  i_bus_data_in
);

  localparam logic [3:0] CMD_NOP      = 4'h0;
  localparam logic [3:0] CMD_PC_READ  = 4'h2;
  localparam logic [3:0] CMD_DP_READ  = 4'h3;
  localparam logic [3:0] CMD_DP_WRITE = 4'h5;
  localparam logic [3:0] CMD_LOAD_PC  = 4'h6;
  localparam logic [3:0] CMD_LOAD_DP  = 4'h7;
  localparam logic [3:0] CMD_RESET    = 4'hF;

  localparam logic [2:0] OP_FETCH  = 3'd0;
  localparam logic [2:0] OP_JUMP   = 3'd1;
  localparam logic [2:0] OP_SETDP  = 3'd2;
  localparam logic [2:0] OP_DPRD   = 3'd3;
  localparam logic [2:0] OP_DPWR   = 3'd4;
  localparam logic [2:0] OP_BUSRST = 3'd5;

  // ST_WAIT: request accepted, waiting for the next bus-cycle boundary.
  typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_CMD, ST_ADDR, ST_DATA} state_t;

  state_t      state_reg;
  logic        busy_reg;
  logic        done_reg;
  logic        strobe_reg;
  logic        cmd_data_reg;
  logic [3:0]  data_out_reg;
  logic [3:0]  rdata_reg;
  logic [3:0]  last_cmd_reg;
  logic [3:0]  wdata_reg;
  logic [2:0]  op_reg;
  logic [2:0]  nib_reg;
  logic [19:0] pc_reg;
  logic [19:0] dp_reg;
  logic [19:0] addr_reg;
  logic [19:0] addr_sh_reg;

  logic [3:0]  req_cmd;
  logic [3:0]  data_nib;
  logic        is_load;
  logic        need_cmd;
  logic        last_cycle;

  always_comb begin
    req_cmd = CMD_NOP;
    case (op_reg)
      OP_FETCH:  req_cmd = CMD_PC_READ;
      OP_JUMP:   req_cmd = CMD_LOAD_PC;
      OP_SETDP:  req_cmd = CMD_LOAD_DP;
      OP_DPRD:   req_cmd = CMD_DP_READ;
      OP_DPWR:   req_cmd = CMD_DP_WRITE;
      OP_BUSRST: req_cmd = CMD_RESET;
      default:   req_cmd = CMD_NOP;
    endcase
    is_load    = (op_reg == OP_JUMP) || (op_reg == OP_SETDP);
    // Loads and bus resets always need their command; others only on change.
    need_cmd   = is_load || (op_reg == OP_BUSRST) || (req_cmd != last_cmd_reg);
    data_nib   = (op_reg == OP_DPWR) ? wdata_reg : 4'h0;
    last_cycle = ((state_reg == ST_CMD) && (op_reg == OP_BUSRST)) ||
                 ((state_reg == ST_ADDR) && (nib_reg == 3'd4)) ||
                 (state_reg == ST_DATA);
  end

  // Strobe free-runs regardless of reset so responders keep their timing.
  always_ff @(posedge i_clk) begin
    strobe_reg <= (i_phase == 2'd0);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_reg    <= ST_IDLE;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      cmd_data_reg <= 1'b1;
      data_out_reg <= 4'h0;
      rdata_reg    <= 4'h0;
      last_cmd_reg <= CMD_NOP;
      wdata_reg    <= 4'h0;
      op_reg       <= OP_FETCH;
      nib_reg      <= 3'd0;
      pc_reg       <= 20'h0;
      dp_reg       <= 20'h0;
      addr_reg     <= 20'h0;
      addr_sh_reg  <= 20'h0;
    end else begin
      done_reg <= 1'b0;

      if (!busy_reg && i_req && (i_op <= OP_BUSRST)) begin
        op_reg    <= i_op;
        addr_reg  <= i_addr;
        wdata_reg <= i_wdata;
        busy_reg  <= 1'b1;
        state_reg <= ST_WAIT;
      end

      // Bus outputs only move on the edge that closes phase 3.
      if (i_phase == 2'd3) begin
        if (last_cycle) begin
          state_reg    <= ST_IDLE;
          busy_reg     <= 1'b0;
          done_reg     <= 1'b1;
          cmd_data_reg <= 1'b1;
          data_out_reg <= 4'h0;
        end

        case (state_reg)
          ST_WAIT: begin
            if (need_cmd) begin
              state_reg    <= ST_CMD;
              cmd_data_reg <= 1'b0;
              data_out_reg <= req_cmd;
              last_cmd_reg <= req_cmd;
            end else begin
              state_reg    <= ST_DATA;
              cmd_data_reg <= 1'b1;
              data_out_reg <= data_nib;
            end
          end
          ST_CMD: begin
            if (op_reg == OP_BUSRST) begin
              last_cmd_reg <= CMD_NOP;
            end else if (is_load) begin
              state_reg    <= ST_ADDR;
              nib_reg      <= 3'd0;
              cmd_data_reg <= 1'b1;
              data_out_reg <= addr_reg[3:0];
              addr_sh_reg  <= {4'h0, addr_reg[19:4]};
            end else begin
              state_reg    <= ST_DATA;
              cmd_data_reg <= 1'b1;
              data_out_reg <= data_nib;
            end
          end
          ST_ADDR: begin
            if (nib_reg == 3'd4) begin
              // Responder's pointer now holds the address and auto-reads from it.
              if (op_reg == OP_JUMP) begin
                pc_reg       <= addr_reg;
                last_cmd_reg <= CMD_PC_READ;
              end else begin
                dp_reg       <= addr_reg;
                last_cmd_reg <= CMD_DP_READ;
              end
            end else begin
              nib_reg      <= nib_reg + 3'd1;
              data_out_reg <= addr_sh_reg[3:0];
              addr_sh_reg  <= {4'h0, addr_sh_reg[19:4]};
            end
          end
          ST_DATA: begin
            case (op_reg)
              OP_FETCH: begin
                rdata_reg <= i_bus_data_in;
                pc_reg    <= pc_reg + 20'd1;
              end
              OP_DPRD: begin
                rdata_reg <= i_bus_data_in;
                dp_reg    <= dp_reg + 20'd1;
              end
              OP_DPWR: dp_reg <= dp_reg + 20'd1;
              default: ;
            endcase
          end
          default: ;
        endcase
      end
    end
  end

  assign o_busy         = busy_reg;
  assign o_done         = done_reg;
  assign o_rdata        = rdata_reg;
  assign o_pc           = pc_reg;
  assign o_dp           = dp_reg;
  assign o_bus_strobe   = strobe_reg;
  assign o_bus_cmd_data = cmd_data_reg;
  assign o_bus_data_out = data_out_reg;

endmodule
